// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-add per clock, LSB first, busy/done handshake.
// Ports: clk, rst_n, start, a, b -> busy, done, sum [, cout when SERIAL_ADDER_COUT_EN].
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_ADDER_COUT_EN
  output logic [WIDTH-1:0] sum,
  output logic             cout
`else
  output logic [WIDTH-1:0] sum
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_s       = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c       = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign w_acc_nxt = {w_s, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
`ifdef SERIAL_ADDER_COUT_EN
      cout    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_c;
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            sum     <= w_acc_nxt;
`ifdef SERIAL_ADDER_COUT_EN
            cout    <= w_c;
`endif
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8).
// Scoreboard queue of expected {cout,sum}, popped on each done pulse.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_COUT_EN
  logic         cout;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
`ifdef SERIAL_ADDER_COUT_EN
    .sum   (sum),
    .cout  (cout)
`else
    .sum   (sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc_n = 0;
  int         n_done = 0;
  int         busy_cnt = 0;
  int         done_cyc = 0;
  logic [W:0] q[$];
  int         dq[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the rising edge, score any done pulse.
  task automatic tick();
    logic [W:0] e;
    @(posedge clk);
    #1;
    cyc_n++;
    if (busy) busy_cnt++;
    chk("busy_done_excl", 32'(busy & done), 0);
    if (done) begin
      n_done++;
      done_cyc = cyc_n;
      dq.push_back(cyc_n);
      chk("done_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e[W-1:0]));
`ifdef SERIAL_ADDER_COUT_EN
        chk("cout", 32'(cout), 32'(e[W]));
`endif
      end
    end
  endtask

  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib);
    int c0;
    int nd0;
    q.push_back({1'b0, ia} + {1'b0, ib});
    a = ia;
    b = ib;
    start = 1'b1;
    busy_cnt = 0;
    nd0 = n_done;
    tick();
    start = 1'b0;
    a = ~ia;
    b = ~ib;
    c0 = cyc_n;
    for (int k = 0; k < 20 && n_done == nd0; k++) tick();
    chk("done_seen", 32'(n_done - nd0), 1);
    chk("latency", 32'(done_cyc - c0), W);
    chk("busy_cycles", 32'(busy_cnt), W);
    tick();
    chk("done_pulse_1cyc", 32'(done), 0);
  endtask

  initial begin
    int nd0;
    start = 1'b0;
    a = '0;
    b = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
`ifdef SERIAL_ADDER_COUT_EN
    chk("rst_cout", 32'(cout), 0);
`endif
    rst_n = 1'b1;
    tick();

    op(8'h00, 8'h00);
    op(8'h5A, 8'h25);
    op(8'hFF, 8'h01);
    op(8'h80, 8'h80);
    op(8'hA7, 8'h3C);

    // start held high: one result every W+2 cycles
    dq.delete();
    nd0 = n_done;
    repeat (3) q.push_back(9'h030);
    a = 8'h10;
    b = 8'h20;
    start = 1'b1;
    for (int k = 0; k < 40 && n_done < nd0 + 3; k++) tick();
    start = 1'b0;
    chk("held_dones", 32'(n_done - nd0), 3);
    if (dq.size() >= 3) begin
      chk("held_gap1", 32'(dq[1] - dq[0]), W + 2);
      chk("held_gap2", 32'(dq[2] - dq[1]), W + 2);
    end
    repeat (12) tick();
    chk("held_no_extra", 32'(n_done - nd0), 3);

    // start during RUN is ignored
    nd0 = n_done;
    q.push_back(9'h010);
    a = 8'h0F;
    b = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hAA;
    b = 8'h55;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("ignore_one_done", 32'(n_done - nd0), 1);
    chk("ignore_sum", 32'(sum), 32'h10);

    // reset mid-RUN aborts the operation
    nd0 = n_done;
    a = 8'hC3;
    b = 8'h3C;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("abort_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sum", 32'(sum), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("abort_no_done", 32'(n_done - nd0), 0);
    op(8'h01, 8'h02);
    chk("sb_empty", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
